// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipeline_ctrl_pkg                                      |
// | Description : Shared stall-bus layout, FSM encodings and counter     |
// |               width for the pipeline hazard/stall controller.        |
// | Config      : PIPELINE_CTRL_LOAD_USE_EN (see pipeline_ctrl)          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pipeline_ctrl_pkg;

  // Stall bus layout: one hold bit per pipeline stage
  localparam int STALL_W  = 6;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;

  // Multi-cycle down-counter width (matches ex_mc_cycles)
  localparam int MC_CNT_W = 4;

  // Controller states
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_RUN     = 2'd0;
  localparam logic [ST_W-1:0] ST_MC_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_FLUSH   = 2'd2;

  // Builds a hold mask covering stages pc .. upto (inclusive)
  function automatic logic [STALL_W-1:0] stall_upto(input int upto);
    logic [STALL_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < STALL_W; i++) begin
      if (i <= upto) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // Load-use: hold pc/if/id, EX takes a bubble
  localparam logic [STALL_W-1:0] STALL_NONE     = '0;
  localparam logic [STALL_W-1:0] STALL_LOAD_USE = 6'b000111;
  // Multi-cycle EX: hold everything up to and including EX
  localparam logic [STALL_W-1:0] STALL_MC       = 6'b001111;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_use_detect                                        |
// | Description : Combinational load-use hazard compare between the      |
// |               decode-stage sources and the load destination in EX.   |
// |               Only instantiated with PIPELINE_CTRL_LOAD_USE_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_use_detect (
  input  logic       id_read_enable1,
  input  logic       id_read_enable2,
  input  logic [4:0] id_read_addr1,
  input  logic [4:0] id_read_addr2,
  input  logic       ex_is_load,
  input  logic [4:0] ex_write_addr,
  output logic       hazard
);

  logic w_hit1;
  logic w_hit2;

  // Register 0 is hard-wired zero, so a load into it never creates a dependency
  always_comb begin
    w_hit1 = id_read_enable1 && (id_read_addr1 == ex_write_addr);
    w_hit2 = id_read_enable2 && (id_read_addr2 == ex_write_addr);
    hazard = ex_is_load && (ex_write_addr != 5'd0) && (w_hit1 || w_hit2);
  end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipeline_ctrl                                          |
// | Description : Pipeline stall/flush controller. Handles flush         |
// |               requests, multi-cycle EX operations and (optionally)   |
// |               load-use hazards. Outputs are combinational so ID/EX   |
// |               react in the same cycle.                               |
// | Config      : `define PIPELINE_CTRL_LOAD_USE_EN enables hardware     |
// |               load-use interlock; otherwise software schedules it.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               id_read_enable1,
  input  logic               id_read_enable2,
  input  logic [4:0]         id_read_addr1,
  input  logic [4:0]         id_read_addr2,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_write_addr,
  input  logic               ex_mc_start,
  input  logic [3:0]         ex_mc_cycles,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               busy
);

  logic [ST_W-1:0]     r_state;
  logic [MC_CNT_W-1:0] r_mc_count;
  logic [ST_W-1:0]     w_state_nxt;
  logic [MC_CNT_W-1:0] w_mc_count_nxt;
  logic                w_hazard;

`ifdef PIPELINE_CTRL_LOAD_USE_EN
  load_use_detect u_load_use_detect (
    .id_read_enable1 (id_read_enable1),
    .id_read_enable2 (id_read_enable2),
    .id_read_addr1   (id_read_addr1),
    .id_read_addr2   (id_read_addr2),
    .ex_is_load      (ex_is_load),
    .ex_write_addr   (ex_write_addr),
    .hazard          (w_hazard)
  );
`else
  // Load-use interlock disabled: hazard inputs are intentionally unused
  logic w_unused_load_use;
  assign w_unused_load_use = &{1'b0, id_read_enable1, id_read_enable2, id_read_addr1,
                               id_read_addr2, ex_is_load, ex_write_addr};
  assign w_hazard = 1'b0;
`endif

  // Next-state and output decode; priority is flush > multi-cycle > load-use.
  // In MC_BUSY, mc_count holds the stall cycles still owed including the
  // current one, so the op stalls ex_mc_cycles-1 cycles in total.
  always_comb begin
    stall          = STALL_NONE;
    flush          = 1'b0;
    busy           = 1'b0;
    w_state_nxt    = r_state;
    w_mc_count_nxt = r_mc_count;
    if (reset) begin
      case (r_state)
        ST_RUN: begin
          if (flush_req) begin
            flush       = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else if (ex_mc_start && (ex_mc_cycles >= 4'd2)) begin
            stall          = STALL_MC;
            busy           = 1'b1;
            w_mc_count_nxt = ex_mc_cycles - 4'd2;
            // A two-cycle op is fully covered by this single stall cycle
            w_state_nxt    = (ex_mc_cycles == 4'd2) ? ST_RUN : ST_MC_BUSY;
          end else if (w_hazard) begin
            stall = STALL_LOAD_USE;
          end
        end
        ST_MC_BUSY: begin
          if (flush_req) begin
            flush          = 1'b1;
            w_mc_count_nxt = '0;
            w_state_nxt    = ST_FLUSH;
          end else begin
            stall          = STALL_MC;
            busy           = 1'b1;
            w_mc_count_nxt = (r_mc_count == '0) ? '0 : r_mc_count - 4'd1;
            if (r_mc_count <= 4'd1) w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush       = 1'b1;
          w_state_nxt = flush_req ? ST_FLUSH : ST_RUN;
        end
        default: begin
          w_state_nxt    = ST_RUN;
          w_mc_count_nxt = '0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_mc_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mc_count <= w_mc_count_nxt;
    end
  end

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pipeline_ctrl                                       |
// | Description : Self-checking bench for pipeline_ctrl: directed        |
// |               scenarios plus randomized traffic against a reference  |
// |               model that tracks "stall cycles still owed".           |
// | Config      : honours PIPELINE_CTRL_LOAD_USE_EN                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pipeline_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_read_enable1, id_read_enable2;
  logic [4:0] id_read_addr1, id_read_addr2;
  logic       ex_is_load;
  logic [4:0] ex_write_addr;
  logic       ex_mc_start;
  logic [3:0] ex_mc_cycles;
  logic       flush_req;
  logic [5:0] stall;
  logic       flush;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_owed     = 0;   // multi-cycle stall cycles still owed after this one
  bit m_flushing = 0;   // one-cycle flush window in progress

  logic [5:0] last_stall;
  logic       last_flush;
  logic       last_busy;

  pipeline_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .id_read_enable1 (id_read_enable1),
    .id_read_enable2 (id_read_enable2),
    .id_read_addr1   (id_read_addr1),
    .id_read_addr2   (id_read_addr2),
    .ex_is_load      (ex_is_load),
    .ex_write_addr   (ex_write_addr),
    .ex_mc_start     (ex_mc_start),
    .ex_mc_cycles    (ex_mc_cycles),
    .flush_req       (flush_req),
    .stall           (stall),
    .flush           (flush),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
`ifdef PIPELINE_CTRL_LOAD_USE_EN
    return ex_is_load && (ex_write_addr != 5'd0) &&
           ((id_read_enable1 && id_read_addr1 == ex_write_addr) ||
            (id_read_enable2 && id_read_addr2 == ex_write_addr));
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    id_read_enable1 = 0; id_read_enable2 = 0;
    id_read_addr1 = 0;   id_read_addr2 = 0;
    ex_is_load = 0;      ex_write_addr = 0;
    ex_mc_start = 0;     ex_mc_cycles = 0;
    flush_req = 0;
  endtask

  // One clock: predict outputs from current inputs, compare mid-cycle, advance model
  task automatic cycle(input string tag);
    logic [5:0] e_stall;
    logic       e_flush, e_busy;
    int         n_owed;
    bit         n_flushing;
    e_stall = 6'b0; e_flush = 0; e_busy = 0;
    n_owed = m_owed; n_flushing = m_flushing;
    if (!reset) begin
      n_owed = 0; n_flushing = 0;
    end else if (m_flushing) begin
      e_flush = 1; n_flushing = flush_req;
    end else if (flush_req) begin
      e_flush = 1; n_owed = 0; n_flushing = 1;
    end else if (m_owed > 0) begin
      e_stall = 6'b001111; e_busy = 1; n_owed = m_owed - 1;
    end else if (ex_mc_start && ex_mc_cycles >= 2) begin
      e_stall = 6'b001111; e_busy = 1; n_owed = int'(ex_mc_cycles) - 2;
    end else if (model_hazard()) begin
      e_stall = 6'b000111;
    end
    @(negedge clock);
    last_stall = stall; last_flush = flush; last_busy = busy;
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check({tag, ".busy"},  32'(busy),  32'(e_busy));
    @(posedge clock);
    m_owed = n_owed; m_flushing = n_flushing;
    #1;
  endtask

  // Launch a multi-cycle op and return how many consecutive cycles stalled
  task automatic mc_run(input logic [3:0] cyc, output int len);
    int guard;
    len = 0;
    ex_mc_start = 1; ex_mc_cycles = cyc;
    cycle("mc_start");
    if (last_stall == 6'b001111) len++;
    idle_inputs();
    guard = 0;
    while (last_stall == 6'b001111 && guard < 20) begin
      cycle("mc_busy");
      if (last_stall == 6'b001111) len++;
      guard++;
    end
  endtask

  task automatic load_use_pattern(input logic [4:0] waddr);
    ex_is_load = 1; ex_write_addr = waddr;
    id_read_enable1 = 1; id_read_addr1 = 5'd5;
  endtask

  initial begin
    int len;
    idle_inputs();
    reset = 0;
    // Inputs must be ignored while reset is asserted
    flush_req = 1; ex_mc_start = 1; ex_mc_cycles = 4'd9;
    repeat (3) cycle("reset");
    check("reset.stall", 32'(last_stall), 32'd0);
    idle_inputs();
    reset = 1;
    cycle("run_idle");

    // Load-use on source 1
    load_use_pattern(5'd5);
    cycle("lu_hit");
`ifdef PIPELINE_CTRL_LOAD_USE_EN
    check("lu_hit_direct", 32'(last_stall), 32'h07);
`else
    check("lu_hit_direct", 32'(last_stall), 32'h00);
`endif
    idle_inputs();
    cycle("lu_after");

    // Load into r0 never interlocks
    load_use_pattern(5'd0);
    id_read_addr1 = 5'd0;
    cycle("lu_r0");
    check("lu_r0_direct", 32'(last_stall), 32'h00);
    idle_inputs();

    // Multi-cycle lengths, including the degenerate and maximum cases
    mc_run(4'd4, len);  check("mc4_len", 32'(len), 32'd3);
    mc_run(4'd1, len);  check("mc1_len", 32'(len), 32'd0);
    mc_run(4'd0, len);  check("mc0_len", 32'(len), 32'd0);
    mc_run(4'd2, len);  check("mc2_len", 32'(len), 32'd1);
    mc_run(4'd15, len); check("mc15_len", 32'(len), 32'd14);

    // Flush in the second MC_BUSY cycle
    ex_mc_start = 1; ex_mc_cycles = 4'd6;
    cycle("fl_start");
    idle_inputs();
    cycle("fl_busy1");
    flush_req = 1;
    cycle("fl_abort");
    check("fl_abort_flush", 32'(last_flush), 32'd1);
    check("fl_abort_busy", 32'(last_busy), 32'd0);
    flush_req = 0;
    cycle("fl_window");
    cycle("fl_run");
    check("fl_run_flush", 32'(last_flush), 32'd0);

    // Reset in the middle of MC_BUSY
    ex_mc_start = 1; ex_mc_cycles = 4'd9;
    cycle("rs_start");
    idle_inputs();
    cycle("rs_busy");
    reset = 0;
    cycle("rs_reset");
    reset = 1;
    cycle("rs_release");
    check("rs_release_busy", 32'(last_busy), 32'd0);
    load_use_pattern(5'd5);
    cycle("rs_lu");
    idle_inputs();
    cycle("rs_lu_after");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 39) != 0);
      flush_req       = ($urandom_range(0, 11) == 0);
      ex_mc_start     = ($urandom_range(0, 5) == 0);
      ex_mc_cycles    = 4'($urandom_range(0, 15));
      ex_is_load      = 1'($urandom_range(0, 1));
      ex_write_addr   = 5'($urandom_range(0, 3));
      id_read_enable1 = 1'($urandom_range(0, 1));
      id_read_enable2 = 1'($urandom_range(0, 1));
      id_read_addr1   = 5'($urandom_range(0, 3));
      id_read_addr2   = 5'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
